// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RV32I pipeline.
// Loads and stores go through a req/done handshake with the memory
// controller. The stage stalls upstream while an access is in flight.
// It also drives the MEM/WB registers and a combinational forward to decode.
// Optional feature: define MEM_LOAD_BYPASS_EN to enable a one-entry
// store-to-load bypass buffer for non-IO addresses.
module mem_stage #(
    parameter int          OPT_W   = 6,
    parameter logic [31:0] IO_BASE = 32'h00030000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic [OPT_W-1:0] inst_i,
    input  logic [4:0]       rd_i,
    input  logic [31:0]      vd_i,
    input  logic [31:0]      addr_i,
    input  logic             w_enable_i,
    output logic             mem_req,
    output logic             mem_rw,
    output logic [31:0]      mem_addr,
    output logic [1:0]       mem_len,
    output logic [31:0]      mem_wdata,
    input  logic             mem_done,
    input  logic [31:0]      mem_rdata,
    output logic             stall_o,
    output logic [4:0]       rd_o,
    output logic [31:0]      vd_o,
    output logic             w_enable_o,
    output logic [4:0]       fwd_rd,
    output logic [31:0]      fwd_vd,
    output logic             fwd_we
);
    // instruction codes shared with the rest of the pipeline
    localparam logic [OPT_W-1:0] ZERO_OPT = OPT_W'(0);
    localparam logic [OPT_W-1:0] OPT_LB   = OPT_W'(20);
    localparam logic [OPT_W-1:0] OPT_LH   = OPT_W'(21);
    localparam logic [OPT_W-1:0] OPT_LW   = OPT_W'(22);
    localparam logic [OPT_W-1:0] OPT_LBU  = OPT_W'(23);
    localparam logic [OPT_W-1:0] OPT_LHU  = OPT_W'(24);
    localparam logic [OPT_W-1:0] OPT_SB   = OPT_W'(25);
    localparam logic [OPT_W-1:0] OPT_SH   = OPT_W'(26);
    localparam logic [OPT_W-1:0] OPT_SW   = OPT_W'(27);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    function automatic logic is_load(input logic [OPT_W-1:0] op);
        return op == OPT_LB || op == OPT_LH || op == OPT_LW ||
               op == OPT_LBU || op == OPT_LHU;
    endfunction

    function automatic logic is_store(input logic [OPT_W-1:0] op);
        return op == OPT_SB || op == OPT_SH || op == OPT_SW;
    endfunction

    // bytes-1 encoding of the access width
    function automatic logic [1:0] op_len(input logic [OPT_W-1:0] op);
        case (op)
            OPT_LB, OPT_LBU, OPT_SB: return 2'd0;
            OPT_LH, OPT_LHU, OPT_SH: return 2'd1;
            default:                 return 2'd3;
        endcase
    endfunction

    // controller returns zero-extended data; apply the load's signedness
    function automatic logic [31:0] extend(input logic [OPT_W-1:0] op, input logic [31:0] d);
        case (op)
            OPT_LB:  return {{24{d[7]}}, d[7:0]};
            OPT_LH:  return {{16{d[15]}}, d[15:0]};
            OPT_LBU: return {24'd0, d[7:0]};
            OPT_LHU: return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

    logic [0:0]       state;
    logic [OPT_W-1:0] op_q;     // opcode of the access in flight
    logic             in_mem;
    logic             done_now;
    logic [31:0]      ext_rdata;
    logic             byp_hit;
    logic [31:0]      byp_vd;

    assign in_mem    = is_load(inst_i) || is_store(inst_i);
    assign done_now  = (state == BUSY) && mem_done;
    assign ext_rdata = extend(op_q, mem_rdata);

`ifdef MEM_LOAD_BYPASS_EN
    logic        byp_valid;
    logic [31:0] byp_addr;
    logic [1:0]  byp_len;
    logic [31:0] byp_data;

    assign byp_hit = (state == IDLE) && is_load(inst_i) && byp_valid &&
                     (byp_addr == addr_i) && (byp_len == op_len(inst_i)) &&
                     (addr_i < IO_BASE);
    assign byp_vd  = extend(inst_i, byp_data);

    // record each completed store; IO stores leave the buffer invalid
    always_ff @(posedge clk) begin
        if (rst) begin
            byp_valid <= 1'b0;
            byp_addr  <= '0;
            byp_len   <= '0;
            byp_data  <= '0;
        end else if (rdy && done_now && is_store(op_q)) begin
            byp_valid <= (mem_addr < IO_BASE);
            byp_addr  <= mem_addr;
            byp_len   <= mem_len;
            byp_data  <= mem_wdata;
        end
    end
`else
    assign byp_hit = 1'b0;
    assign byp_vd  = '0;
`endif

    // stall while a handshake is pending or the pipeline is frozen
    always_comb begin
        stall_o = 1'b1;
        if (rdy) begin
            if (state == IDLE) stall_o = in_mem && !byp_hit;
            else               stall_o = !mem_done;
        end
    end

    // same-cycle forward to decode: ALU results in IDLE, load data on completion
    always_comb begin
        fwd_rd = '0;
        fwd_vd = '0;
        fwd_we = 1'b0;
        if (state == IDLE && !in_mem) begin
            fwd_rd = rd_i;
            fwd_vd = vd_i;
            fwd_we = w_enable_i && (inst_i != ZERO_OPT);
        end else if (done_now && is_load(op_q)) begin
            fwd_rd = rd_i;
            fwd_vd = ext_rdata;
            fwd_we = w_enable_i;
        end
    end

    // FSM, memory request registers and MEM/WB outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= ZERO_OPT;
            rd_o       <= '0;
            vd_o       <= '0;
            w_enable_o <= 1'b0;
            mem_req    <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            mem_len    <= '0;
            mem_wdata  <= '0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    if (byp_hit) begin
                        rd_o       <= rd_i;
                        vd_o       <= byp_vd;
                        w_enable_o <= w_enable_i;
                    end else if (in_mem) begin
                        mem_req    <= 1'b1;
                        mem_rw     <= is_store(inst_i);
                        mem_addr   <= addr_i;
                        mem_len    <= op_len(inst_i);
                        mem_wdata  <= vd_i;
                        op_q       <= inst_i;
                        w_enable_o <= 1'b0;
                        state      <= BUSY;
                    end else begin
                        rd_o       <= rd_i;
                        vd_o       <= vd_i;
                        w_enable_o <= w_enable_i && (inst_i != ZERO_OPT);
                    end
                end
                default: begin
                    if (mem_done) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                        if (is_load(op_q)) begin
                            rd_o       <= rd_i;
                            vd_o       <= ext_rdata;
                            w_enable_o <= w_enable_i;
                        end else begin
                            w_enable_o <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed, table-driven bench for mem_stage.
module tb_mem_stage;
    localparam int OPT_W = 6;
    localparam logic [5:0] ZERO = 6'd0,  ADD = 6'd1,  XORI = 6'd7;
    localparam logic [5:0] LB  = 6'd20, LH  = 6'd21, LW = 6'd22;
    localparam logic [5:0] LBU = 6'd23, LHU = 6'd24;
    localparam logic [5:0] SB  = 6'd25, SH  = 6'd26, SW = 6'd27;

    logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1;
    logic [5:0]  inst_i = '0;
    logic [4:0]  rd_i = '0;
    logic [31:0] vd_i = '0, addr_i = '0;
    logic        w_enable_i = 1'b0;
    logic        mem_req, mem_rw;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  mem_len;
    logic        mem_done = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stall_o;
    logic [4:0]  rd_o, fwd_rd;
    logic [31:0] vd_o, fwd_vd;
    logic        w_enable_o, fwd_we;

    int n_chk = 0, n_fail = 0;

    mem_stage #(.OPT_W(OPT_W), .IO_BASE(32'h00030000)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .inst_i(inst_i), .rd_i(rd_i), .vd_i(vd_i),
        .addr_i(addr_i), .w_enable_i(w_enable_i), .mem_req(mem_req), .mem_rw(mem_rw),
        .mem_addr(mem_addr), .mem_len(mem_len), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .stall_o(stall_o), .rd_o(rd_o),
        .vd_o(vd_o), .w_enable_o(w_enable_o), .fwd_rd(fwd_rd), .fwd_vd(fwd_vd),
        .fwd_we(fwd_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] addr,
                         input logic [31:0] vd, input logic we);
        inst_i = op; rd_i = rd; addr_i = addr; vd_i = vd; w_enable_i = we;
    endtask

    // Full handshake: called at a negedge; ends at the negedge after completion.
    task automatic mem_op(input string nm, input logic [5:0] op, input logic [4:0] rd,
                          input logic [31:0] addr, input logic [31:0] vd, input int ncyc,
                          input logic [31:0] rdata, input logic [1:0] exp_len,
                          input logic is_st, input logic [31:0] exp_vd);
        drive(op, rd, addr, vd, 1'b1);
        #1;
        chk({nm, ".issue_stall"}, 32'(stall_o), 32'd1);
        chk({nm, ".issue_noreq"}, 32'(mem_req), 32'd0);
        @(posedge clk);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (i == ncyc - 1) begin
                mem_done = 1'b1;
                mem_rdata = rdata;
            end
            #1;
            chk({nm, ".req"},   32'(mem_req), 32'd1);
            chk({nm, ".rw"},    32'(mem_rw), 32'(is_st));
            chk({nm, ".addr"},  mem_addr, addr);
            chk({nm, ".len"},   32'(mem_len), 32'(exp_len));
            chk({nm, ".stall"}, 32'(stall_o), (i == ncyc - 1) ? 32'd0 : 32'd1);
            if (is_st && i == 0) chk({nm, ".wdata"}, mem_wdata, vd);
            if (i == ncyc - 1) begin
                chk({nm, ".fwd_we"}, 32'(fwd_we), 32'(!is_st));
                if (!is_st) chk({nm, ".fwd_vd"}, fwd_vd, exp_vd);
            end
        end
        @(posedge clk);
        @(negedge clk);
        mem_done = 1'b0;
        mem_rdata = '0;
        chk({nm, ".req_drop"}, 32'(mem_req), 32'd0);
        chk({nm, ".we_o"}, 32'(w_enable_o), 32'(!is_st));
        if (!is_st) begin
            chk({nm, ".rd_o"}, 32'(rd_o), 32'(rd));
            chk({nm, ".vd_o"}, vd_o, exp_vd);
        end
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [31:0] vd;
        logic        we;
        logic [4:0]  e_rd;
        logic [31:0] e_vd;
        logic        e_we;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{ADD,  5'd5,  32'h00001234, 1'b1, 5'd5,  32'h00001234, 1'b1};
        vecs[1] = '{ADD,  5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b1};
        vecs[2] = '{XORI, 5'd0,  32'h00000000, 1'b0, 5'd0,  32'h00000000, 1'b0};
        vecs[3] = '{ZERO, 5'd7,  32'h0000AAAA, 1'b1, 5'd7,  32'h0000AAAA, 1'b0};
        vecs[4] = '{XORI, 5'd12, 32'h80000001, 1'b1, 5'd12, 32'h80000001, 1'b1};

        // reset state
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst.rd_o", 32'(rd_o), 32'd0);
        chk("rst.vd_o", vd_o, 32'd0);
        chk("rst.we_o", 32'(w_enable_o), 32'd0);
        chk("rst.req",  32'(mem_req), 32'd0);
        chk("rst.addr", mem_addr, 32'd0);

        // non-memory instructions: one-cycle latency, no stall
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].op, vecs[i].rd, 32'h0, vecs[i].vd, vecs[i].we);
            #1;
            chk("alu.stall",  32'(stall_o), 32'd0);
            chk("alu.fwd_we", 32'(fwd_we), 32'(vecs[i].e_we));
            chk("alu.fwd_vd", fwd_vd, vecs[i].vd);
            @(posedge clk);
            @(negedge clk);
            chk("alu.rd_o", 32'(rd_o), 32'(vecs[i].e_rd));
            chk("alu.vd_o", vd_o, vecs[i].e_vd);
            chk("alu.we_o", 32'(w_enable_o), 32'(vecs[i].e_we));
        end

        // rdy low freezes outputs and forces stall
        drive(ADD, 5'd9, 32'h0, 32'h99, 1'b1);
        rdy = 1'b0;
        #1;
        chk("rdy.stall", 32'(stall_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("rdy.rd_hold", 32'(rd_o), 32'd12);
        chk("rdy.vd_hold", vd_o, 32'h80000001);
        rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rdy.rd_go", 32'(rd_o), 32'd9);

        // loads and stores, back to back
        mem_op("lb",  LB,  5'd3, 32'h100, 32'h0, 3, 32'h000000F0, 2'd0, 1'b0, 32'hFFFFFFF0);
        mem_op("lhu", LHU, 5'd4, 32'h104, 32'h0, 1, 32'h0000F00F, 2'd1, 1'b0, 32'h0000F00F);
        mem_op("lh",  LH,  5'd6, 32'h106, 32'h0, 2, 32'h0000F00F, 2'd1, 1'b0, 32'hFFFFF00F);
        mem_op("lbu", LBU, 5'd8, 32'h107, 32'h0, 1, 32'h00000080, 2'd0, 1'b0, 32'h00000080);
        mem_op("lw",  LW,  5'd10, 32'h108, 32'h0, 2, 32'h12345678, 2'd3, 1'b0, 32'h12345678);
        mem_op("sw",  SW,  5'd0, 32'h200, 32'hDEADBEEF, 2, 32'h0, 2'd3, 1'b1, 32'h0);
        mem_op("sb",  SB,  5'd0, 32'h201, 32'h000000AB, 1, 32'h0, 2'd0, 1'b1, 32'h0);

        // mem_done in IDLE is ignored
        drive(ZERO, 5'd0, 32'h0, 32'h0, 1'b0);
        mem_done = 1'b1;
        #1;
        chk("idle_done.stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        mem_done = 1'b0;
        chk("idle_done.req", 32'(mem_req), 32'd0);

        // reset during BUSY aborts the request
        drive(LW, 5'd2, 32'h400, 32'h0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("abort.req_busy", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(ZERO, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("abort.req",   32'(mem_req), 32'd0);
        chk("abort.addr",  mem_addr, 32'd0);
        chk("abort.len",   32'(mem_len), 32'd0);
        chk("abort.wdata", mem_wdata, 32'd0);
        chk("abort.vd_o",  vd_o, 32'd0);
        chk("abort.we_o",  32'(w_enable_o), 32'd0);
        mem_done = 1'b1;
        mem_rdata = 32'h55555555;
        #1;
        chk("abort.late_done_stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        mem_done = 1'b0;
        mem_rdata = '0;
        chk("abort.late_done_vd", vd_o, 32'd0);
        chk("abort.late_done_we", 32'(w_enable_o), 32'd0);

        // store-then-load to the same address
        mem_op("byp_sw", SW, 5'd0, 32'h200, 32'hCAFEF00D, 2, 32'h0, 2'd3, 1'b1, 32'h0);
`ifdef MEM_LOAD_BYPASS_EN
        drive(LW, 5'd11, 32'h200, 32'h0, 1'b1);
        #1;
        chk("byp_lw.stall", 32'(stall_o), 32'd0);
        chk("byp_lw.req",   32'(mem_req), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("byp_lw.req_after", 32'(mem_req), 32'd0);
        chk("byp_lw.vd_o", vd_o, 32'hCAFEF00D);
        chk("byp_lw.we_o", 32'(w_enable_o), 32'd1);
        chk("byp_lw.rd_o", 32'(rd_o), 32'd11);
`else
        mem_op("byp_lw", LW, 5'd11, 32'h200, 32'h0, 1, 32'hCAFEF00D, 2'd3, 1'b0, 32'hCAFEF00D);
`endif
        // IO region always goes through the handshake
        mem_op("io_sw", SW, 5'd0, 32'h30000, 32'hCAFEF00D, 1, 32'h0, 2'd3, 1'b1, 32'h0);
        mem_op("io_lw", LW, 5'd13, 32'h30000, 32'h0, 2, 32'h0BADF00D, 2'd3, 1'b0, 32'h0BADF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
